fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: size, 32, datapath and instruction width.
REQ-002 Parameter: RESET_PC, 32'h0000_2000, boot and PC_sel==2 vector.
REQ-003 Parameter: INSTR_NOP, 32'h0000_0013, bubble encoding (addi x0,x0,0).
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 PC_sel  in  2  0 = sequential, 1 = redirect to alu_target, 2 = redirect to RESET_PC; 3 is treated as 0.
REQ-007 NOP  in  1  kill the instruction currently presented on instr_X.
REQ-008 alu_target  in  size  branch/jump target computed in X.
REQ-009 stall  in  1  X not accepting a new instruction this cycle.
REQ-010 imem_req_valid  out  1  fetch request valid.
REQ-011 imem_req_addr  out  size  fetch address; word-aligned.
REQ-012 imem_req_ready  in  1  memory accepts the request.
REQ-013 imem_resp_valid  in  1  response data valid; arrives at least 1 cycle after acceptance.
REQ-014 imem_resp_data  in  size  fetched instruction word.
REQ-015 instr_X  out  size  instruction presented to X.
REQ-016 pc_X  out  size  PC of instr_X.
REQ-017 instr_valid_X  out  1  instr_X is a real instruction (0 = bubble).

Function
REQ-018 States: REQ (drive request), WAIT (one request accepted, response pending), HELD (response captured in the 1-entry skid register, waiting for stall release).
REQ-019 At most one request outstanding; imem_req_valid = 1 only in REQ; imem_req_addr = pc_F in REQ and holds stable until imem_req_ready.
REQ-020 REQ -> WAIT on imem_req_valid && imem_req_ready; the accepted address is latched as pc_req.
REQ-021 WAIT with imem_resp_valid, stall=0, no kill: instr_X <= data, pc_X <= pc_req, instr_valid_X <= 1, pc_F <= pc_req+4, next state REQ.
REQ-022 WAIT with imem_resp_valid, stall=1: capture data/pc_req in skid register, instr_X unchanged, next state HELD.
REQ-023 HELD with stall=0: skid contents move to instr_X/pc_X, instr_valid_X <= 1, pc_F <= skid_pc+4, next state REQ.
REQ-024 Without redirect, stall=1 holds instr_X, pc_X and instr_valid_X unchanged.
REQ-025 Redirect (PC_sel==1 or 2) has priority over stall and any response in the same cycle: pc_F <= alu_target (1) or RESET_PC (2); skid entry dropped; next state REQ.
REQ-026 Redirect while in WAIT with no response in the same cycle: the kill flag is set and the state stays WAIT; the pending response is discarded on arrival, then next state REQ at the new pc_F; the kill flag is cleared then.
REQ-027 NOP=1: instr_X <= INSTR_NOP, instr_valid_X <= 0 at the edge, regardless of stall; pc_X unchanged.
REQ-028 PC arithmetic is modulo 2^size; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-029 alu_target bits [1:0] are forced to 0 before loading pc_F.
REQ-030 A kill flag set by a redirect during WAIT never discards more than one response.

Reset
REQ-031 On rst=1, asynchronously: state REQ, pc_F = RESET_PC, instr_X = INSTR_NOP, pc_X = RESET_PC, instr_valid_X = 0, kill flag = 0, skid empty.
REQ-032 Reset mid-transaction discards any outstanding response.
REQ-033 imem_req_valid may assert in the first cycle after rst deasserts.
REQ-034 Until the first delivered instruction, instr_X holds INSTR_NOP.

Verification
REQ-035 Boot test: rst released, ready=1, 1-cycle memory -> addresses 0x2000, 0x2004, 0x2008 fetched; instr_X/pc_X follow in order, with instr_valid_X=1.
REQ-036 Backpressure test: imem_req_ready low for 3 cycles -> imem_req_addr holds 0x2004 stable; no duplicate or skipped PC.
REQ-037 Stall test: stall=1 when a response arrives -> instr_X unchanged; state HELD. Release stall -> the skid word appears next cycle; the next fetch is skid_pc+4.
REQ-038 Redirect test: PC_sel=1, NOP=1, alu_target=0x3001 while in WAIT -> the response is dropped; the next request is 0x3000; instr_X=0x00000013 with instr_valid_X=0.
REQ-039 Collision test: PC_sel=2 in the same cycle as imem_resp_valid with stall=1 -> the response is discarded; the next request is RESET_PC.
REQ-040 Async reset test: rst asserted mid-WAIT -> outputs reach reset values before the next clock edge; a late response is ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end.
//   Issues one word-aligned fetch at a time on a valid/ready request port and
//   delivers the returned word to the execute stage (X). A one-entry skid
//   register absorbs a response that arrives while X is stalled. Redirects
//   from X (branch/jump target or reset vector) drop or kill in-flight work.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   PC_sel[1:0]                   0/3 sequential, 1 alu_target, 2 RESET_PC
//   NOP                           turn the instruction on instr_X into a bubble
//   alu_target[size-1:0]          redirect target from X
//   stall                         X not accepting a new instruction
//   imem_req_valid/addr/ready     fetch request handshake
//   imem_resp_valid/data          fetch response
//   instr_X, pc_X, instr_valid_X  instruction presented to X
module fetch_stage #(
  parameter int          size      = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_2000,
  parameter logic [31:0] INSTR_NOP = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      PC_sel,
  input  logic            NOP,
  input  logic [size-1:0] alu_target,
  input  logic            stall,
  output logic            imem_req_valid,
  output logic [size-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [size-1:0] imem_resp_data,
  output logic [size-1:0] instr_X,
  output logic [size-1:0] pc_X,
  output logic            instr_valid_X
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HELD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [size-1:0] pc_f_q, pc_f_d;
  logic [size-1:0] pc_req_q, pc_req_d;
  logic            kill_q, kill_d;
  logic [size-1:0] skid_instr_q, skid_instr_d;
  logic [size-1:0] skid_pc_q, skid_pc_d;
  logic [size-1:0] instr_x_q, instr_x_d;
  logic [size-1:0] pc_x_q, pc_x_d;
  logic            instr_valid_x_q, instr_valid_x_d;

  logic            redirect;
  logic [size-1:0] redirect_pc;

  assign redirect    = (PC_sel == 2'd1) || (PC_sel == 2'd2);
  assign redirect_pc = (PC_sel == 2'd1) ? {alu_target[size-1:2], 2'b00}
                                        : RESET_PC[size-1:0];

  // A request is withheld in a redirect cycle so that a request for the stale
  // PC can never be accepted; this keeps the single-outstanding rule intact.
  assign imem_req_valid = (state_q == S_REQ) && !redirect;
  assign imem_req_addr  = pc_f_q;

  assign instr_X       = instr_x_q;
  assign pc_X          = pc_x_q;
  assign instr_valid_X = instr_valid_x_q;

  always_comb begin
    state_d         = state_q;
    pc_f_d          = pc_f_q;
    pc_req_d        = pc_req_q;
    kill_d          = kill_q;
    skid_instr_d    = skid_instr_q;
    skid_pc_d       = skid_pc_q;
    instr_x_d       = instr_x_q;
    pc_x_d          = pc_x_q;
    instr_valid_x_d = instr_valid_x_q;

    unique case (state_q)
      S_REQ: begin
        if (redirect) begin
          pc_f_d = redirect_pc;
        end else if (imem_req_ready) begin
          pc_req_d = pc_f_q;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_f_d = redirect_pc;
          if (imem_resp_valid) begin
            // The response arriving with the redirect is simply dropped.
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else if (stall) begin
            skid_instr_d = imem_resp_data;
            skid_pc_d    = pc_req_q;
            state_d      = S_HELD;
          end else begin
            instr_x_d       = imem_resp_data;
            pc_x_d          = pc_req_q;
            instr_valid_x_d = 1'b1;
            pc_f_d          = pc_req_q + size'(4);
            state_d         = S_REQ;
          end
        end
      end
      S_HELD: begin
        if (redirect) begin
          pc_f_d  = redirect_pc;
          state_d = S_REQ;
        end else if (!stall) begin
          instr_x_d       = skid_instr_q;
          pc_x_d          = skid_pc_q;
          instr_valid_x_d = 1'b1;
          pc_f_d          = skid_pc_q + size'(4);
          state_d         = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    // A kill from X wins over any delivery in the same cycle.
    if (NOP) begin
      instr_x_d       = INSTR_NOP[size-1:0];
      instr_valid_x_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_REQ;
      pc_f_q          <= RESET_PC[size-1:0];
      pc_req_q        <= RESET_PC[size-1:0];
      kill_q          <= 1'b0;
      skid_instr_q    <= '0;
      skid_pc_q       <= '0;
      instr_x_q       <= INSTR_NOP[size-1:0];
      pc_x_q          <= RESET_PC[size-1:0];
      instr_valid_x_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_f_q          <= pc_f_d;
      pc_req_q        <= pc_req_d;
      kill_q          <= kill_d;
      skid_instr_q    <= skid_instr_d;
      skid_pc_q       <= skid_pc_d;
      instr_x_q       <= instr_x_d;
      pc_x_q          <= pc_x_d;
      instr_valid_x_q <= instr_valid_x_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: a cycle table of inputs with
// hand-computed request outputs (before the edge) and X outputs (after it),
// followed by a hand-written asynchronous reset sequence.
module tb_fetch_stage;

  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  PC_sel;
  logic        NOP;
  logic [31:0] alu_target;
  logic        stall;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] instr_X;
  logic [31:0] pc_X;
  logic        instr_valid_X;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .PC_sel         (PC_sel),
    .NOP            (NOP),
    .alu_target     (alu_target),
    .stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .instr_X        (instr_X),
    .pc_X           (pc_X),
    .instr_valid_X  (instr_valid_X)
  );

  typedef struct {
    logic [1:0]  sel;
    logic        nop;
    logic [31:0] tgt;
    logic        stl;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        e_rv;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_vld;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] sel, input logic nop, input logic [31:0] tgt,
                     input logic stl, input logic rdy, input logic rv, input logic [31:0] rdata,
                     input logic e_rv, input logic [31:0] e_addr,
                     input logic [31:0] e_instr, input logic [31:0] e_pc, input logic e_vld);
    vec_t v;
    v.sel = sel; v.nop = nop; v.tgt = tgt; v.stl = stl; v.rdy = rdy; v.rv = rv;
    v.rdata = rdata; v.e_rv = e_rv; v.e_addr = e_addr; v.e_instr = e_instr;
    v.e_pc = e_pc; v.e_vld = e_vld;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    PC_sel = 2'd0; NOP = 1'b0; alu_target = '0; stall = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
  endtask

  initial begin
    // sel nop tgt stall rdy rv rdata | e_rv e_addr e_instr e_pc e_vld
    // boot and backpressure
    add(0,0,0,0,1,0,0,            1,32'h2000,NOPW,32'h2000,0);          // 0  REQ 2000 accepted
    add(0,0,0,0,1,1,32'hA000_2000,0,32'h2000,32'hA000_2000,32'h2000,1); // 1  deliver
    add(0,0,0,0,0,0,0,            1,32'h2004,32'hA000_2000,32'h2000,1); // 2  ready low
    add(0,0,0,0,0,0,0,            1,32'h2004,32'hA000_2000,32'h2000,1); // 3
    add(0,0,0,0,0,0,0,            1,32'h2004,32'hA000_2000,32'h2000,1); // 4
    add(0,0,0,0,1,0,0,            1,32'h2004,32'hA000_2000,32'h2000,1); // 5  accepted
    add(0,0,0,0,1,1,32'hA000_2004,0,32'h2004,32'hA000_2004,32'h2004,1); // 6
    add(0,0,0,0,1,0,0,            1,32'h2008,32'hA000_2004,32'h2004,1); // 7
    add(0,0,0,0,1,1,32'hA000_2008,0,32'h2008,32'hA000_2008,32'h2008,1); // 8
    // stall into skid
    add(0,0,0,0,1,0,0,            1,32'h200C,32'hA000_2008,32'h2008,1); // 9
    add(0,0,0,1,1,1,32'hA000_200C,0,32'h200C,32'hA000_2008,32'h2008,1); // 10 captured, HELD
    add(0,0,0,1,1,0,0,            0,32'h200C,32'hA000_2008,32'h2008,1); // 11 still held
    add(0,0,0,0,1,0,0,            0,32'h200C,32'hA000_200C,32'h200C,1); // 12 skid released
    add(0,0,0,0,1,0,0,            1,32'h2010,32'hA000_200C,32'h200C,1); // 13 next fetch skid_pc+4
    // redirect with kill during WAIT
    add(1,1,32'h3001,0,1,0,0,     0,32'h2010,NOPW,32'h200C,0);          // 14
    add(0,0,0,0,1,1,32'hBAD0_2010,0,32'h3000,NOPW,32'h200C,0);          // 15 stale dropped
    add(0,0,0,0,1,0,0,            1,32'h3000,NOPW,32'h200C,0);          // 16
    add(0,0,0,0,1,1,32'hC000_3000,0,32'h3000,32'hC000_3000,32'h3000,1); // 17
    // redirect to reset vector colliding with a stalled response
    add(0,0,0,0,1,0,0,            1,32'h3004,32'hC000_3000,32'h3000,1); // 18
    add(2,0,0,1,1,1,32'hBAD0_3004,0,32'h3004,32'hC000_3000,32'h3000,1); // 19
    add(0,0,0,0,0,0,0,            1,32'h2000,32'hC000_3000,32'h3000,1); // 20
    // PC_sel 3 behaves as sequential
    add(3,0,0,0,1,0,0,            1,32'h2000,32'hC000_3000,32'h3000,1); // 21
    add(3,0,0,0,1,1,32'hD000_2000,0,32'h2000,32'hD000_2000,32'h2000,1); // 22
    // wrap-around of the PC and target alignment
    add(1,0,32'hFFFF_FFFF,0,0,0,0,0,32'h2004,32'hD000_2000,32'h2000,1); // 23
    add(0,0,0,0,1,0,0,            1,32'hFFFF_FFFC,32'hD000_2000,32'h2000,1); // 24
    add(0,0,0,0,1,1,32'hE000_FFFC,0,32'hFFFF_FFFC,32'hE000_FFFC,32'hFFFF_FFFC,1); // 25
    add(0,0,0,0,0,0,0,            1,32'h0000_0000,32'hE000_FFFC,32'hFFFF_FFFC,1); // 26
    // NOP while stalled
    add(0,1,0,1,0,0,0,            1,32'h0000_0000,NOPW,32'hFFFF_FFFC,0); // 27

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_instr", instr_X, NOPW);
    chk("reset_pc", pc_X, 32'h2000);
    chk("reset_vld", {31'b0, instr_valid_X}, 32'd0);
    chk("reset_req_addr", imem_req_addr, 32'h2000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      PC_sel = v.sel; NOP = v.nop; alu_target = v.tgt; stall = v.stl;
      imem_req_ready = v.rdy; imem_resp_valid = v.rv; imem_resp_data = v.rdata;
      #1;
      chk($sformatf("v%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, v.e_rv});
      chk($sformatf("v%0d_req_addr", i), imem_req_addr, v.e_addr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_instr", i), instr_X, v.e_instr);
      chk($sformatf("v%0d_pc", i), pc_X, v.e_pc);
      chk($sformatf("v%0d_vld", i), {31'b0, instr_valid_X}, {31'b0, v.e_vld});
      @(negedge clk);
    end

    // Async reset mid-WAIT: first deliver a real instruction at PC 0.
    idle_inputs();
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hF000_0000;
    @(negedge clk);
    idle_inputs();
    imem_req_ready = 1'b1;
    @(negedge clk);
    chk("pre_rst_instr", instr_X, 32'hF000_0000);
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_instr", instr_X, NOPW);
    chk("async_rst_pc", pc_X, 32'h2000);
    chk("async_rst_vld", {31'b0, instr_valid_X}, 32'd0);
    chk("async_rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("async_rst_req_addr", imem_req_addr, 32'h2000);
    // Late response while reset is held, and in the cycle after release.
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hBAD0_0004;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("late_resp_instr", instr_X, NOPW);
    chk("late_resp_vld", {31'b0, instr_valid_X}, 32'd0);
    chk("late_resp_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("late_resp_req_addr", imem_req_addr, 32'h2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
